// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues single-outstanding imem requests,
// and buffers {pc+4, instr} pairs in a small FIFO feeding the IF/ID register.
module fetch_queue #(
    parameter int                 WIDTH    = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [WIDTH-1:0]           imem_addr,
    input  logic                       imem_ack,
    input  logic [WIDTH-1:0]           imem_rdata,
    input  logic                       redirect,
    input  logic [WIDTH-1:0]           redirect_pc,
    input  logic                       id_ld,
    output logic                       id_valid,
    output logic [WIDTH-1:0]           id_instr,
    output logic [WIDTH-1:0]           id_pc_plus4,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int             AW    = $clog2(DEPTH);
    localparam logic [AW:0]    FULL  = (AW+1)'(DEPTH);
    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [WIDTH-1:0] imem_addr_q, imem_addr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push, pop;

    logic [WIDTH-1:0] instr_mem [DEPTH];
    logic [WIDTH-1:0] pc4_mem   [DEPTH];

    assign imem_req    = (state_q != IDLE);
    assign imem_addr   = imem_addr_q;
    assign count       = count_q;
    assign id_valid    = (count_q != '0);
    assign id_instr    = id_valid ? instr_mem[rd_ptr_q] : '0;
    assign id_pc_plus4 = id_valid ? pc4_mem[rd_ptr_q]   : '0;

    // A redirect wins over both queue ports: nothing is pushed or popped that cycle.
    always_comb begin
        push     = (state_q == REQ) && imem_ack && !redirect;
        pop      = id_valid && id_ld && !redirect;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        imem_addr_d = imem_addr_q;
        unique case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d  = redirect_pc;
                    imem_addr_d = redirect_pc;
                    state_d     = REQ;
                end else if (count_d < FULL) begin
                    imem_addr_d = fetch_pc_q;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (redirect && imem_ack) begin
                    fetch_pc_d  = redirect_pc;
                    imem_addr_d = redirect_pc;
                end else if (redirect) begin
                    // Memory still owes us a response for the old address; wait it out.
                    fetch_pc_d = redirect_pc;
                    state_d    = DROP;
                end else if (imem_ack) begin
                    fetch_pc_d  = fetch_pc_q + PC_STEP;
                    imem_addr_d = fetch_pc_q + PC_STEP;
                    state_d     = (count_d < FULL) ? REQ : IDLE;
                end
            end
            DROP: begin
                if (redirect) fetch_pc_d = redirect_pc;
                if (imem_ack) begin
                    imem_addr_d = redirect ? redirect_pc : fetch_pc_q;
                    state_d     = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            imem_addr_q <= RESET_PC;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_addr_q <= imem_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // NOTE: storage is not reset; the id_* outputs are masked by id_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= imem_rdata;
            pc4_mem[wr_ptr_q]   <= imem_addr_q + PC_STEP;
        end
    end

endmodule
